// File: rtl/bky_pkg.sv
// Shared constants and majority voting for the BuckEye loader and chain shifter.
package bky_pkg;

  localparam int NWORDS    = 18;
  localparam int WORD_W    = 16;
  localparam int CHAIN_LEN = NWORDS * WORD_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DRAIN = 2'd2
  } frame_st_e;

  // Every control flop of the shifter lives in this struct so that one
  // register bank can be triplicated and voted as a unit.
  typedef struct packed {
    frame_st_e  st;
    logic [3:0] bit_idx;
    logic [4:0] word_cnt;
    logic [8:0] bit_cnt;
    logic       sticky;
    logic       set_done_q;
    logic       pend;
    logic       sdi;
    logic       busy;
    logic       rbk_vld;
    logic       load_err;
  } ctrl_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic ctrl_t maj_ctrl(input ctrl_t a, input ctrl_t b, input ctrl_t c);
    return ctrl_t'((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/bky_rbk_sreg.sv
// Readback shift register: one returned chain bit enters per BKY_CLK pulse.
module bky_rbk_sreg
  import bky_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cap_en,
  input  logic                 sdo,
  output logic [CHAIN_LEN-1:0] data
);

  // first bit returned ends up in the MSB once the whole chain has passed
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)         data <= '0;
    else if (cap_en) data <= {data[CHAIN_LEN-2:0], sdo};
  end

endmodule

// File: rtl/bky_chain_shifter.sv
// BuckEye daisy-chain serialiser with readback capture and frame checking.
//
// state    | meaning
// ST_IDLE  | no frame open; waits for RDENA with SET_DONE low
// ST_FRAME | words are being shifted; watches for SET_DONE rising
// ST_DRAIN | last readback bit lands; status is published on exit
module bky_chain_shifter
  import bky_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WORD_W-1:0]    DIN,
  input  logic                 RDENA,
  input  logic                 SHFT_ENA,
  input  logic                 SET_DONE,
  input  logic                 BKY_SDO,
  output logic                 BKY_SDI,
  output logic                 BKY_CLK,
  output logic [CHAIN_LEN-1:0] RBK_DATA,
  output logic                 RBK_VLD,
  output logic                 LOAD_ERR,
  output logic                 BUSY
);

  ctrl_t      q0, q1, q2, cur, nxt;
  frame_st_e  st_nxt;
  logic       in_frame, rd_start, sd_rise;
  logic [3:0] idx;
  logic [2:0] clk_r, clk_f;
  logic       r_v, f_v;

  assign cur      = maj_ctrl(q0, q1, q2);
  assign in_frame = (cur.st != ST_IDLE);
  assign rd_start = RDENA && !in_frame && !SET_DONE;
  assign sd_rise  = SET_DONE && !cur.set_done_q;

  // triplicated control register bank, all copies reloaded from the voted next value
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q0 <= '0;
      q1 <= '0;
      q2 <= '0;
    end else begin
      q0 <= nxt;
      q1 <= nxt;
      q2 <= nxt;
    end
  end

  // frame sequencing; SET_DONE outside a frame is ignored
  always_comb begin
    st_nxt = cur.st;
    case (cur.st)
      ST_IDLE:  if (rd_start) st_nxt = ST_FRAME;
      ST_FRAME: if (sd_rise)  st_nxt = ST_DRAIN;
      ST_DRAIN: st_nxt = ST_IDLE;
      default:  st_nxt = ST_IDLE;
    endcase
  end

  // counters, serial data and status; a same-cycle RDENA restarts the word before the shift
  always_comb begin
    nxt            = cur;
    nxt.st         = st_nxt;
    nxt.set_done_q = SET_DONE;
    nxt.pend       = SHFT_ENA;
    idx            = cur.bit_idx;
    if (RDENA) begin
      nxt.bit_idx = '0;
      idx         = '0;
      if (rd_start) begin
        nxt.busy     = 1'b1;
        nxt.rbk_vld  = 1'b0;
        nxt.load_err = 1'b0;
        nxt.bit_cnt  = '0;
        nxt.word_cnt = 5'd1;
        nxt.sticky   = 1'b0;
      end else if (in_frame && cur.word_cnt != 5'd31) begin
        nxt.word_cnt = cur.word_cnt + 5'd1;
      end
    end
    if (SHFT_ENA) begin
      nxt.sdi     = DIN[4'(WORD_W - 1) - idx];
      nxt.bit_idx = idx + 4'd1;
      if (in_frame && cur.bit_cnt != 9'd511) nxt.bit_cnt = cur.bit_cnt + 9'd1;
      if (RDENA || !in_frame) nxt.sticky = 1'b1;
    end
    if (cur.st == ST_DRAIN) begin
      nxt.busy     = 1'b0;
      nxt.rbk_vld  = 1'b1;
      nxt.load_err = (cur.bit_cnt != 9'(CHAIN_LEN)) ||
                     (cur.word_cnt != 5'(NWORDS)) || cur.sticky;
    end
  end

  assign r_v = maj3(clk_r[0], clk_r[1], clk_r[2]);
  assign f_v = maj3(clk_f[0], clk_f[1], clk_f[2]);

  // rising half: copying the falling flop returns BKY_CLK low at every rising edge
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) clk_r <= '0;
    else     clk_r <= {3{f_v}};
  end

  // falling half: a pending shift makes the pair differ, raising BKY_CLK for half a cycle
  always_ff @(negedge CLK or posedge RST) begin
    if (RST) clk_f <= '0;
    else     clk_f <= {3{cur.pend ^ r_v}};
  end

  // outputs straight from voted flops; BKY_CLK is the XOR of two flops on opposite edges
  always_comb begin
    BKY_SDI  = cur.sdi;
    BKY_CLK  = f_v ^ r_v;
    RBK_VLD  = cur.rbk_vld;
    LOAD_ERR = cur.load_err;
    BUSY     = cur.busy;
  end

  bky_rbk_sreg u_rbk (
    .CLK    (CLK),
    .RST    (RST),
    .cap_en (cur.pend),
    .sdo    (BKY_SDO),
    .data   (RBK_DATA)
  );

endmodule

// File: tb/tb_bky_chain_shifter.sv
// Directed bench: loader FSM model on the falling edge, 288-bit chain model on BKY_CLK.
module tb_bky_chain_shifter;
  import bky_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [WORD_W-1:0] DIN = '0;
  logic RDENA = 1'b0, SHFT_ENA = 1'b0, SET_DONE = 1'b0;
  logic BKY_SDO, BKY_SDI, BKY_CLK;
  logic [CHAIN_LEN-1:0] RBK_DATA;
  logic RBK_VLD, LOAD_ERR, BUSY;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WORD_W-1:0]    words [NWORDS];
  logic [CHAIN_LEN-1:0] chain = '0;
  logic [CHAIN_LEN-1:0] exp_stream, preload;
  logic                 sdo_m = 1'b0;
  int                   pulse_cnt = 0;
  realtime              t_fall = 0.0;
  realtime              min_low = 1.0e9;
  logic                 vld1, vld2, busy2, err2, busy_mid;

  assign BKY_SDO = sdo_m;

  always #5 CLK = ~CLK;

  bky_chain_shifter dut (
    .CLK      (CLK),
    .RST      (RST),
    .DIN      (DIN),
    .RDENA    (RDENA),
    .SHFT_ENA (SHFT_ENA),
    .SET_DONE (SET_DONE),
    .BKY_SDO  (BKY_SDO),
    .BKY_SDI  (BKY_SDI),
    .BKY_CLK  (BKY_CLK),
    .RBK_DATA (RBK_DATA),
    .RBK_VLD  (RBK_VLD),
    .LOAD_ERR (LOAD_ERR),
    .BUSY     (BUSY)
  );

  // chain model: chips take SDI on the rising BKY_CLK and present SDO after the falling one
  always @(posedge BKY_CLK) begin
    chain <= {chain[CHAIN_LEN-2:0], BKY_SDI};
    pulse_cnt = pulse_cnt + 1;
    if ($realtime - t_fall < min_low) min_low = $realtime - t_fall;
  end

  always @(negedge BKY_CLK) begin
    sdo_m <= chain[CHAIN_LEN-1];
    t_fall = $realtime;
  end

  task automatic load_chain(input logic [CHAIN_LEN-1:0] v);
    chain = v;
    sdo_m = v[CHAIN_LEN-1];
  endtask

  // loader FSM model: RDENA cycle, 16 shift cycles per word, then SET_DONE
  task automatic run_frame(input int nw, input int inject_at, input int abort_at);
    int ns;
    ns = 0;
    pulse_cnt = 0;
    for (int w = 0; w < nw; w++) begin
      @(negedge CLK); SHFT_ENA = 1'b0; RDENA = 1'b1; DIN = words[w];
      for (int b = 0; b < WORD_W; b++) begin
        @(negedge CLK);
        if (w == 0 && b == 0) busy_mid = BUSY;
        RDENA = (ns == inject_at);
        SHFT_ENA = 1'b1;
        ns++;
        if (ns == abort_at) begin
          @(negedge CLK); SHFT_ENA = 1'b0; RDENA = 1'b0;
          return;
        end
      end
    end
    @(negedge CLK); SHFT_ENA = 1'b0; RDENA = 1'b0; SET_DONE = 1'b1;
    @(negedge CLK); vld1 = RBK_VLD;
    @(negedge CLK); vld2 = RBK_VLD; busy2 = BUSY; err2 = LOAD_ERR;
    @(negedge CLK); SET_DONE = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_cmp++; if ({BKY_SDI, BKY_CLK, RBK_VLD, LOAD_ERR, BUSY} !== 5'b0) begin
      n_bad++; $display("FAIL rst_outs got=%b exp=00000", {BKY_SDI, BKY_CLK, RBK_VLD, LOAD_ERR, BUSY}); end
    n_cmp++; if (RBK_DATA !== '0) begin
      n_bad++; $display("FAIL rst_rbk got=%h exp=0", RBK_DATA); end
    RST = 1'b0;
    @(negedge CLK); SET_DONE = 1'b1; RDENA = 1'b1;
    @(negedge CLK); RDENA = 1'b0;
    repeat (3) @(negedge CLK);
    n_cmp++; if (BUSY !== 1'b0) begin
      n_bad++; $display("FAIL rden_under_done_busy got=%b exp=0", BUSY); end
    n_cmp++; if (RBK_VLD !== 1'b0) begin
      n_bad++; $display("FAIL idle_done_vld got=%b exp=0", RBK_VLD); end
    SET_DONE = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_nominal();
    logic [CHAIN_LEN-1:0] z;
    logic [WORD_W-1:0]    w0;
    z = '0;
    load_chain(z);
    run_frame(NWORDS, -1, 0);
    w0 = chain[CHAIN_LEN-1 -: WORD_W];
    n_cmp++; if (busy_mid !== 1'b1) begin
      n_bad++; $display("FAIL nom_busy_mid got=%b exp=1", busy_mid); end
    n_cmp++; if (pulse_cnt !== CHAIN_LEN) begin
      n_bad++; $display("FAIL nom_pulses got=%0d exp=%0d", pulse_cnt, CHAIN_LEN); end
    n_cmp++; if (w0 !== 16'h8001) begin
      n_bad++; $display("FAIL nom_first_sdi got=%h exp=8001", w0); end
    n_cmp++; if (chain !== exp_stream) begin
      n_bad++; $display("FAIL nom_sdi_stream got=%h exp=%h", chain, exp_stream); end
    n_cmp++; if (vld1 !== 1'b0 || vld2 !== 1'b1) begin
      n_bad++; $display("FAIL nom_vld_timing got=%b%b exp=01", vld1, vld2); end
    n_cmp++; if (err2 !== 1'b0 || busy2 !== 1'b0) begin
      n_bad++; $display("FAIL nom_err_busy got=%b%b exp=00", err2, busy2); end
    n_cmp++; if (RBK_DATA !== z) begin
      n_bad++; $display("FAIL nom_rbk got=%h exp=0", RBK_DATA); end
  endtask

  task automatic test_loopback();
    preload = {36{8'hA5}};
    load_chain(preload);
    repeat (3) @(negedge CLK);
    run_frame(NWORDS, -1, 0);
    n_cmp++; if (RBK_DATA !== preload) begin
      n_bad++; $display("FAIL loop_rbk1 got=%h exp=%h", RBK_DATA, preload); end
    n_cmp++; if (err2 !== 1'b0 || vld2 !== 1'b1) begin
      n_bad++; $display("FAIL loop_status1 err/vld got=%b%b exp=01", err2, vld2); end
    repeat (3) @(negedge CLK);
    run_frame(NWORDS, -1, 0);
    n_cmp++; if (RBK_DATA !== exp_stream) begin
      n_bad++; $display("FAIL loop_rbk2 got=%h exp=%h", RBK_DATA, exp_stream); end
  endtask

  task automatic test_short_frame();
    repeat (3) @(negedge CLK);
    run_frame(NWORDS - 1, -1, 0);
    n_cmp++; if (pulse_cnt !== CHAIN_LEN - WORD_W) begin
      n_bad++; $display("FAIL short_pulses got=%0d exp=%0d", pulse_cnt, CHAIN_LEN - WORD_W); end
    n_cmp++; if (vld2 !== 1'b1 || err2 !== 1'b1) begin
      n_bad++; $display("FAIL short_status vld/err got=%b%b exp=11", vld2, err2); end
  endtask

  task automatic test_rden_shft_overlap();
    repeat (3) @(negedge CLK);
    run_frame(NWORDS, 85, 0);
    n_cmp++; if (pulse_cnt !== CHAIN_LEN) begin
      n_bad++; $display("FAIL ovl_pulses got=%0d exp=%0d", pulse_cnt, CHAIN_LEN); end
    n_cmp++; if (vld2 !== 1'b1 || err2 !== 1'b1) begin
      n_bad++; $display("FAIL ovl_status vld/err got=%b%b exp=11", vld2, err2); end
  endtask

  task automatic test_reset_mid_frame();
    repeat (3) @(negedge CLK);
    run_frame(NWORDS, -1, 100);
    #1;
    n_cmp++; if (BKY_CLK !== 1'b1 || BUSY !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre_rst clk/busy got=%b%b exp=11", BKY_CLK, BUSY); end
    RST = 1'b1;
    #1;
    n_cmp++; if ({BKY_SDI, BKY_CLK, RBK_VLD, LOAD_ERR, BUSY} !== 5'b0) begin
      n_bad++; $display("FAIL mid_rst_outs got=%b exp=00000", {BKY_SDI, BKY_CLK, RBK_VLD, LOAD_ERR, BUSY}); end
    n_cmp++; if (RBK_DATA !== '0) begin
      n_bad++; $display("FAIL mid_rst_rbk got=%h exp=0", RBK_DATA); end
    @(negedge CLK); RST = 1'b0;
    repeat (2) @(negedge CLK);
    run_frame(NWORDS, -1, 0);
    n_cmp++; if (vld2 !== 1'b1 || err2 !== 1'b0 || pulse_cnt !== CHAIN_LEN) begin
      n_bad++; $display("FAIL mid_next_frame vld/err got=%b%b exp=10 pulses=%0d", vld2, err2, pulse_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [CHAIN_LEN-1:0] q;
    q = {NWORDS{16'h3C5A}};
    repeat (3) @(negedge CLK);
    load_chain(q);
    min_low = 1.0e9;
    run_frame(NWORDS, -1, 0);
    n_cmp++; if (RBK_DATA !== q || pulse_cnt !== CHAIN_LEN) begin
      n_bad++; $display("FAIL b2b_first rbk=%h exp=%h pulses=%0d", RBK_DATA, q, pulse_cnt); end
    run_frame(NWORDS, -1, 0);
    n_cmp++; if (vld1 !== 1'b0 || vld2 !== 1'b1 || err2 !== 1'b0) begin
      n_bad++; $display("FAIL b2b_status vld1/vld2/err got=%b%b%b exp=010", vld1, vld2, err2); end
    n_cmp++; if (RBK_DATA !== exp_stream) begin
      n_bad++; $display("FAIL b2b_rbk got=%h exp=%h", RBK_DATA, exp_stream); end
    n_cmp++; if (pulse_cnt !== CHAIN_LEN) begin
      n_bad++; $display("FAIL b2b_pulses got=%0d exp=%0d", pulse_cnt, CHAIN_LEN); end
    n_cmp++; if (min_low < 5.0) begin
      n_bad++; $display("FAIL b2b_min_low got=%0f exp>=5", min_low); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    words[0] = 16'h8001;
    for (int i = 1; i < NWORDS; i++) words[i] = 16'(i + 1);
    exp_stream = '0;
    for (int i = 0; i < NWORDS; i++) exp_stream[CHAIN_LEN-1-WORD_W*i -: WORD_W] = words[i];
    test_reset();
    test_nominal();
    test_loopback();
    test_short_frame();
    test_rden_shft_overlap();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
